pcileech_tlps128_src_demux3: RTL and testbench

//  Inverse of the TX sink mux: one 128-bit TLP-AXI-STREAM from the PCIe core RX path is classified
//  on its header beat, and each whole packet is steered to one of three sinks:
//  cfg shadow, BAR controller, or host FIFO/filter path.

---
 rtl/pcileech_tlps128_src_demux3_pkg.sv | 16 +
 rtl/pcileech_tlps128_src_demux3_if.sv | 14 +
 rtl/pcileech_tlps128_src_demux3_out_reg.sv | 42 ++++
 rtl/pcileech_tlps128_src_demux3.sv | 64 ++++++
 tb/tb_pcileech_tlps128_src_demux3.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_tlps128_src_demux3_pkg.sv
// pcileech_tlp_pkg: TLP fmt/type codes, route and state enums, header classifier for the RX demux.
package pcileech_tlp_pkg;
    localparam logic [7:0] FT_CFGRD = 8'h04;
    localparam logic [7:0] FT_CFGWR = 8'h44;
    localparam logic [7:0] FT_MRD32 = 8'h00;
    localparam logic [7:0] FT_MRD64 = 8'h20;
    localparam logic [7:0] FT_MWR32 = 8'h40;
    localparam logic [7:0] FT_MWR64 = 8'h60;
    typedef enum logic [1:0] {RT_CFG, RT_BAR, RT_OTH, RT_DROP} route_t;
    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} demux_state_t;
    // Bit 0 of the type is the cfg type0/type1 select, so it is ignored for CFG matching.
    function automatic route_t classify(input logic [7:0] h);
        return (h[7:1] == FT_CFGRD[7:1] || h[7:1] == FT_CFGWR[7:1]) ? RT_CFG :
               (h == FT_MRD32 || h == FT_MRD64 || h == FT_MWR32 || h == FT_MWR64) ? RT_BAR : RT_OTH;
    endfunction
endpackage

// File: rtl/pcileech_tlps128_src_demux3_if.sv
// IfAXIS128: 128-bit TLP AXI-stream bundle with source/sink (alias master/slave) views.
interface IfAXIS128;
    logic [127:0] tdata;
    logic [3:0]   tkeepdw;
    logic [8:0]   tuser;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic         has_data;
    modport source(output tdata, tkeepdw, tuser, tlast, tvalid, has_data, input tready);
    modport sink(input tdata, tkeepdw, tuser, tlast, tvalid, has_data, output tready);
    modport master(output tdata, tkeepdw, tuser, tlast, tvalid, has_data, input tready);
    modport slave(input tdata, tkeepdw, tuser, tlast, tvalid, has_data, output tready);
endinterface

// File: rtl/pcileech_tlps128_src_demux3_out_reg.sv
// pcileech_tlps128_out_reg: one-entry AXIS pipe register; load and unload in one cycle replaces the entry.
module pcileech_tlps128_out_reg (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [127:0]  tdata,
    input  logic [3:0]    tkeepdw,
    input  logic [8:0]    tuser,
    input  logic          tlast,
    IfAXIS128.source      m
);
    logic         valid_q, valid_d, last_q, last_d;
    logic [8:0]   user_q, user_d;
    logic [3:0]   keep_q, keep_d;
    logic [127:0] data_q, data_d;
    always_comb begin
        valid_d = load || (valid_q && !m.tready);
        data_d  = load ? tdata : data_q;
        keep_d  = load ? tkeepdw : keep_q;
        user_d  = load ? tuser : user_q;
        last_d  = load ? tlast : last_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
        data_q <= data_d;
        keep_q <= keep_d;
    end
    assign m.tvalid   = valid_q;
    assign m.has_data = valid_q;
    assign m.tdata    = data_q;
    assign m.tkeepdw  = keep_q;
    assign m.tuser    = user_q;
    assign m.tlast    = last_q;
endmodule

// File: rtl/pcileech_tlps128_src_demux3.sv
// pcileech_tlps128_src_demux3: steers whole RX TLPs to cfg / bar / other sinks by header class.
module pcileech_tlps128_src_demux3 import pcileech_tlp_pkg::*; #(
    parameter int CNT_W = 16
) (
    input  logic             clk_pcie,
    input  logic             rst,
    IfAXIS128.sink           tlps_in,
    IfAXIS128.source         tlps_cfg,
    IfAXIS128.source         tlps_bar,
    IfAXIS128.source         tlps_oth,
    input  logic [2:0]       route_en,
    output logic [CNT_W-1:0] pkt_cnt_cfg,
    output logic [CNT_W-1:0] pkt_cnt_bar,
    output logic [CNT_W-1:0] pkt_cnt_oth,
    output logic [CNT_W-1:0] drop_cnt
);
    demux_state_t     state_q, state_d;
    route_t           route_q, route_d, cls, route;
    logic [3:0]       out_valid, out_ready;
    logic [2:0]       load;
    logic             acc, fin;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] drop_q, drop_d;
    // Slot 3 is the drop sink: never full, always ready.
    assign out_valid = {1'b0, tlps_oth.tvalid, tlps_bar.tvalid, tlps_cfg.tvalid};
    assign out_ready = {1'b1, tlps_oth.tready, tlps_bar.tready, tlps_cfg.tready};
    always_comb begin
        cls   = classify(tlps_in.tdata[31:24]);
        route = (state_q != S_DROP && tlps_in.tuser[0]) ? (route_en[cls] ? cls : RT_DROP) :
                (state_q == S_PASS) ? route_q : RT_DROP;
        tlps_in.tready = !rst && (!out_valid[route] || out_ready[route]);
        acc     = tlps_in.tvalid && tlps_in.tready;
        fin     = acc && tlps_in.tlast;
        load    = {3{acc}} & 3'(4'b0001 << route);
        state_d = !acc ? state_q : tlps_in.tlast ? S_IDLE : (route == RT_DROP) ? S_DROP : S_PASS;
        route_d = acc ? route : route_q;
        for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i] + CNT_W'(load[i] && tlps_in.tlast);
        drop_d  = drop_q + CNT_W'(fin && route == RT_DROP && !(&drop_q));
    end
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state_q <= S_IDLE;
            route_q <= RT_DROP;
            cnt_q   <= '{default: '0};
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end
    pcileech_tlps128_out_reg u_cfg (.clk(clk_pcie), .rst(rst), .load(load[0]), .tdata(tlps_in.tdata),
        .tkeepdw(tlps_in.tkeepdw), .tuser(tlps_in.tuser), .tlast(tlps_in.tlast), .m(tlps_cfg));
    pcileech_tlps128_out_reg u_bar (.clk(clk_pcie), .rst(rst), .load(load[1]), .tdata(tlps_in.tdata),
        .tkeepdw(tlps_in.tkeepdw), .tuser(tlps_in.tuser), .tlast(tlps_in.tlast), .m(tlps_bar));
    pcileech_tlps128_out_reg u_oth (.clk(clk_pcie), .rst(rst), .load(load[2]), .tdata(tlps_in.tdata),
        .tkeepdw(tlps_in.tkeepdw), .tuser(tlps_in.tuser), .tlast(tlps_in.tlast), .m(tlps_oth));
    assign pkt_cnt_cfg = cnt_q[0];
    assign pkt_cnt_bar = cnt_q[1];
    assign pkt_cnt_oth = cnt_q[2];
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_pcileech_tlps128_src_demux3.sv
// tb_pcileech_tlps128_src_demux3: packet-level reference model feeding per-output scoreboards.
module tb_pcileech_tlps128_src_demux3;
    typedef logic [141:0] beat_t;
    logic        clk_pcie = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  route_en = 3'b111;
    logic [15:0] pc_cfg, pc_bar, pc_oth, dcnt;
    logic [2:0]  rdy = 3'b111;
    logic [2:0]  v;
    beat_t       ob [3];
    beat_t       exq [3][$];
    int          m_cnt [3] = '{0, 0, 0};
    int          m_drop = 0;
    int          mode [3] = '{1, 1, 1};
    int          tests = 0, fails = 0;
    logic [7:0]  hdrs [12] = '{8'h04, 8'h05, 8'h44, 8'h45, 8'h00, 8'h20, 8'h40, 8'h60, 8'h4A, 8'h0A, 8'h4C, 8'h02};

    IfAXIS128 tin(), tc(), tbr(), to();
    assign tc.tready  = rdy[0];
    assign tbr.tready = rdy[1];
    assign to.tready  = rdy[2];

    always #5 clk_pcie = ~clk_pcie;

    pcileech_tlps128_src_demux3 #(.CNT_W(16)) dut (
        .clk_pcie(clk_pcie), .rst(rst), .tlps_in(tin), .tlps_cfg(tc), .tlps_bar(tbr), .tlps_oth(to),
        .route_en(route_en), .pkt_cnt_cfg(pc_cfg), .pkt_cnt_bar(pc_bar), .pkt_cnt_oth(pc_oth), .drop_cnt(dcnt)
    );

    // Classification from the header's fmt/type fields.
    function automatic int cls_of(input logic [7:0] h);
        logic [2:0] fmt = h[7:5];
        logic [4:0] typ = h[4:0];
        if ((fmt == 3'b000 || fmt == 3'b010) && typ[4:1] == 4'b0010) return 0;
        if (fmt <= 3'd3 && typ == 5'd0) return 1;
        return 2;
    endfunction

    task automatic chk(input string name, input beat_t got, input beat_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // The ready for the coming edge is chosen here, and any transfer it allows is checked now.
    always @(negedge clk_pcie) begin
        v = {to.tvalid, tbr.tvalid, tc.tvalid};
        ob[0] = {tc.tdata, tc.tkeepdw, tc.tuser, tc.tlast};
        ob[1] = {tbr.tdata, tbr.tkeepdw, tbr.tuser, tbr.tlast};
        ob[2] = {to.tdata, to.tkeepdw, to.tuser, to.tlast};
        for (int k = 0; k < 3; k++) begin
            rdy[k] = mode[k] == 1 ? 1'b1 : mode[k] == 2 ? 1'b0 : ($urandom_range(3) != 0);
            if (v[k] && rdy[k]) begin
                if (exq[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out%0d unexpected beat got %h exp none", k, ob[k]);
                end else chk($sformatf("out%0d beat", k), ob[k], exq[k].pop_front());
            end
        end
    end

    task automatic beat(input logic [127:0] d, input logic [3:0] k, input logic [8:0] u, input logic l, output int cyc);
        logic a = 1'b0;
        tin.tdata = d; tin.tkeepdw = k; tin.tuser = u; tin.tlast = l; tin.tvalid = 1'b1;
        cyc = 0;
        while (!a && cyc < 1000) begin
            #3 a = tin.tready;
            @(posedge clk_pcie);
            @(negedge clk_pcie);
            cyc++;
        end
        tin.tvalid = 1'b0;
        if (!a) begin
            tests++;
            fails++;
            $display("FAIL beat accept timeout got %0d cycles exp <1000", cyc);
        end
    endtask

    task automatic send_pkt(input logic [7:0] h, input int n, input bit first, input bit gaps);
        int c = cls_of(h);
        bit ok = first && route_en[c];
        int cyc;
        logic [127:0] d;
        logic [3:0] k;
        logic [8:0] u;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) d[31:24] = h;
            k = 4'($urandom);
            u = {8'($urandom), first && i == 0};
            if (ok) exq[c].push_back({d, k, u, i == n - 1});
            beat(d, k, u, i == n - 1, cyc);
            if (gaps && $urandom_range(3) == 0) begin
                @(posedge clk_pcie);
                @(negedge clk_pcie);
            end
        end
        if (ok) m_cnt[c]++; else m_drop++;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (exq[0].size() + exq[1].size() + exq[2].size()) > 0; i++) @(negedge clk_pcie);
        @(negedge clk_pcie);
        chk("drain cfg", exq[0].size(), 0);
        chk("drain bar", exq[1].size(), 0);
        chk("drain oth", exq[2].size(), 0);
    endtask

    task automatic chk_cnt();
        chk("pkt_cnt_cfg", pc_cfg, 16'(m_cnt[0]));
        chk("pkt_cnt_bar", pc_bar, 16'(m_cnt[1]));
        chk("pkt_cnt_oth", pc_oth, 16'(m_cnt[2]));
        chk("drop_cnt", dcnt, 16'(m_drop));
    endtask

    initial begin
        int cyc, tot;
        logic [127:0] d1, d2, d3;
        tin.tvalid = 1'b0; tin.tdata = '0; tin.tkeepdw = '0; tin.tuser = '0; tin.tlast = 1'b0; tin.has_data = 1'b0;
        repeat (3) @(negedge clk_pcie);
        #3 chk("reset tready", tin.tready, 0);
        chk("reset tvalid", {tc.tvalid, tbr.tvalid, to.tvalid}, 0);
        chk("reset tuser/tlast", {tc.tuser, tc.tlast, tbr.tuser, tbr.tlast, to.tuser, to.tlast}, 0);
        chk_cnt();
        @(negedge clk_pcie);
        rst = 1'b0;
        // CfgRd single beat: visible on cfg one clock after acceptance.
        d1 = {$urandom, $urandom, $urandom, 8'h04, 24'($urandom)};
        exq[0].push_back({d1, 4'b0111, 9'h001, 1'b1});
        m_cnt[0]++;
        beat(d1, 4'b0111, 9'h001, 1'b1, cyc);
        chk("t1 cfg tvalid", tc.tvalid, 1);
        chk("t1 bar/oth tvalid", {tbr.tvalid, to.tvalid}, 0);
        chk("t1 pkt_cnt_cfg", pc_cfg, 16'(m_cnt[0]));
        drain();
        // MWr32 with bar stalled after the first beat.
        mode[1] = 2;
        d1 = {$urandom, $urandom, $urandom, 8'h40, 24'($urandom)};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        d3 = {$urandom, $urandom, $urandom, $urandom};
        exq[1].push_back({d1, 4'b1111, 9'h001, 1'b0});
        exq[1].push_back({d2, 4'b1111, 9'h000, 1'b0});
        exq[1].push_back({d3, 4'b0011, 9'h000, 1'b1});
        m_cnt[1]++;
        beat(d1, 4'b1111, 9'h001, 1'b0, cyc);
        tin.tdata = d2; tin.tkeepdw = 4'b1111; tin.tuser = 9'h000; tin.tlast = 1'b0; tin.tvalid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #3 chk("t2 stall tready", tin.tready, 0);
            if (j == 3) mode[1] = 1;
            @(posedge clk_pcie);
            @(negedge clk_pcie);
        end
        beat(d2, 4'b1111, 9'h000, 1'b0, cyc);
        beat(d3, 4'b0011, 9'h000, 1'b1, cyc);
        drain();
        chk("t2 pkt_cnt_bar", pc_bar, 16'(m_cnt[1]));
        // CplD then CfgWr back to back: three beats in three clocks.
        d1 = {$urandom, $urandom, $urandom, 8'h4A, 24'($urandom)};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        d3 = {$urandom, $urandom, $urandom, 8'h44, 24'($urandom)};
        exq[2].push_back({d1, 4'hF, 9'h001, 1'b0});
        exq[2].push_back({d2, 4'h7, 9'h000, 1'b1});
        exq[0].push_back({d3, 4'h7, 9'h001, 1'b1});
        m_cnt[2]++;
        m_cnt[0]++;
        beat(d1, 4'hF, 9'h001, 1'b0, cyc);
        tot = cyc;
        beat(d2, 4'h7, 9'h000, 1'b1, cyc);
        tot += cyc;
        beat(d3, 4'h7, 9'h001, 1'b1, cyc);
        tot += cyc;
        chk("t3 cycles", tot, 3);
        drain();
        // Disabled bar route: both memory reads are swallowed without stalling.
        route_en = 3'b101;
        beat({96'h0, 8'h20, 24'h0}, 4'hF, 9'h001, 1'b1, cyc);
        tot = cyc;
        beat({96'h0, 8'h00, 24'h0}, 4'h7, 9'h001, 1'b1, cyc);
        tot += cyc;
        m_drop += 2;
        chk("t4 cycles", tot, 2);
        drain();
        chk_cnt();
        // Randomized traffic with random back-pressure, gaps, route masks and headless packets.
        mode = '{0, 0, 0};
        for (int p = 0; p < 200; p++) begin
            route_en = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b111;
            send_pkt($urandom_range(3) == 0 ? 8'($urandom) : hdrs[$urandom_range(11)],
                     $urandom_range(1, 4), $urandom_range(9) != 0, 1'b1);
        end
        mode = '{1, 1, 1};
        route_en = 3'b111;
        drain();
        chk_cnt();
        // Reset in the middle of an MWr64; the headless tail must be dropped.
        d1 = {$urandom, $urandom, $urandom, 8'h60, 24'($urandom)};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        exq[1].push_back({d1, 4'hF, 9'h001, 1'b0});
        exq[1].push_back({d2, 4'hF, 9'h000, 1'b0});
        beat(d1, 4'hF, 9'h001, 1'b0, cyc);
        beat(d2, 4'hF, 9'h000, 1'b0, cyc);
        rst = 1'b1;
        #3 chk("t5 tready in reset", tin.tready, 0);
        @(posedge clk_pcie);
        @(negedge clk_pcie);
        rst = 1'b0;
        m_cnt = '{0, 0, 0};
        m_drop = 0;
        chk("t5 tvalid cleared", {tc.tvalid, tbr.tvalid, to.tvalid}, 0);
        chk_cnt();
        send_pkt(8'h60, 2, 1'b0, 1'b0);
        send_pkt(8'h04, 1, 1'b1, 1'b0);
        drain();
        chk_cnt();
        // Wrap of the oth packet counter.
        for (int p = 0; p < 65537; p++) send_pkt(8'h4A, 1, 1'b1, 1'b0);
        drain();
        chk("t6 pkt_cnt_oth wrap", pc_oth, 16'd1);
        chk_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
